// File: rtl/tff_toggle_arbiter.sv
// tff_toggle_arbiter
//   One WIDTH-bit bank of T flip-flops shared by NUM_REQ requesters. A
//   round-robin arbiter picks one requester at a time. The bank then toggles
//   every bit set in that requester's mask. This block is the only writer of
//   the bank.
//
// Ports
//   clk    in   1              rising-edge clock
//   rst_n  in   1              asynchronous active-low reset
//   req    in   NUM_REQ        per-requester request, held with its mask stable until ack
//   mask   in   NUM_REQ*WIDTH  toggle masks, requester i uses mask[i*WIDTH +: WIDTH]
//   hold   in   1              1 = start no new grants (a grant already in flight completes)
//   clr    in   1              synchronous clear of the bank, wins over a toggle on the same edge
//   ack    out  NUM_REQ        one-hot, one-cycle grant acknowledge
//   q      out  WIDTH          bank state
//   qb     out  WIDTH          always ~q
//   busy   out  1              1 while the FSM is in GRANT, which also exposes the FSM state
//
// Handshake: a requester raises req with its mask stable. It waits for its
// ack bit, which is high for exactly one cycle. It drops req during that
// cycle. If req is still high at the next IDLE sample, that is a new request.
// The mask is captured on the edge that enters GRANT, so later mask changes
// are ignored. The toggle becomes visible after the edge that leaves GRANT.
module tff_toggle_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] mask,
    input  logic                     hold,
    input  logic                     clr,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qb,
    output logic                     busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gidx;
    logic [WIDTH-1:0]  mask_r;
    logic [WIDTH-1:0]  bank;

    logic              found;
    logic [PW-1:0]     win;
    logic [WIDTH-1:0]  win_mask;
    logic              grant_start;
    int                idx;

    // Round-robin search: take the first set req bit at or above ptr.
    // The search wraps from NUM_REQ-1 back to 0.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_mask = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = PW'(idx);
                win_mask = mask[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_start = 1'b0;
        case (state)
            IDLE: begin
                if (!hold && found) begin
                    grant_start = 1'b1;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gidx   <= '0;
            mask_r <= '0;
            bank   <= '0;
        end else begin
            state <= state_next;
            if (grant_start) begin
                gidx   <= win;
                mask_r <= win_mask;
            end
            // The pointer advances on leaving GRANT, even when clr discards the toggle.
            if (state == GRANT) begin
                if (gidx == PW'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gidx + 1'b1;
                end
            end
            if (clr) begin
                bank <= '0;
            end else if (state == GRANT) begin
                bank <= bank ^ mask_r;
            end
        end
    end

    // ack and busy are decoded from state alone, so an asynchronous reset
    // in the middle of GRANT removes them at once.
    always_comb begin
        ack = '0;
        if (state == GRANT) begin
            ack[gidx] = 1'b1;
        end
    end

    assign busy = (state == GRANT);
    assign q    = bank;
    assign qb   = ~bank;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
module tb_tff_toggle_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    // ---------------- clock / reset / DUT ----------------
    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] mask;
    logic                     hold;
    logic                     clr;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         q;
    logic [WIDTH-1:0]         qb;
    logic                     busy;

    always #5 clk = ~clk;

    tff_toggle_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .mask (mask),
        .hold (hold),
        .clr  (clr),
        .ack  (ack),
        .q    (q),
        .qb   (qb),
        .busy (busy)
    );

    // ---------------- scoreboard ----------------
    logic [NUM_REQ-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack !== '0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got %b expected none at %0t", ack, $time);
            end else begin
                chk("ack_order", 32'(ack), 32'(exp_q.pop_front()));
                chk("busy_with_ack", 32'(busy), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int i, input logic [WIDTH-1:0] m);
        mask[i*WIDTH +: WIDTH] = m;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qb", 32'(qb), 32'hFF);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_release_q", 32'(q), 32'h00);
    endtask

    // One requester, one grant: the request is dropped during the ack cycle.
    task automatic single_grant(input int i, input logic [WIDTH-1:0] m);
        set_mask(i, m);
        req[i] = 1'b1;
        exp_q.push_back(NUM_REQ'(1) << i);
        cyc(1);
        req[i] = 1'b0;
        cyc(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = '0;
        mask  = '0;
        hold  = 1'b0;
        clr   = 1'b0;

        // 1. reset
        do_reset();

        // 2. single requester, mask 0F twice
        single_grant(0, 8'h0F);
        chk("single_q1", 32'(q), 32'h0F);
        single_grant(0, 8'h0F);
        chk("single_q2", 32'(q), 32'h00);

        // 3. all four at once from pointer 0: order 0,1,2,3
        do_reset();
        set_mask(0, 8'h01);
        set_mask(1, 8'h02);
        set_mask(2, 8'h04);
        set_mask(3, 8'h08);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        req = 4'b1111;
        begin
            bit done;
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                cyc(1);
                if (ack !== '0) req = req & ~ack;
                if (req == '0) done = 1'b1;
            end
            chk("all_drain", 32'(done), 32'd1);
        end
        req = '0;
        cyc(1);
        chk("all_q", 32'(q), 32'h0F);
        chk("all_qb", 32'(qb), 32'hF0);

        // 4. fairness: req0 (zero mask) and req2 held high for four grants
        set_mask(0, 8'h00);
        set_mask(2, 8'h30);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        req = 4'b0101;
        cyc(8);
        req = '0;
        cyc(2);
        chk("fair_q", 32'(q), 32'h0F);

        // 5. clr wins over the toggle on the edge leaving GRANT
        do_reset();
        single_grant(1, 8'hAA);
        chk("clr_setup_q", 32'(q), 32'hAA);
        set_mask(1, 8'hFF);
        req[1] = 1'b1;
        exp_q.push_back(4'b0010);
        cyc(1);
        chk("clr_busy", 32'(busy), 32'd1);
        req[1] = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr_q", 32'(q), 32'h00);
        chk("clr_qb", 32'(qb), 32'hFF);

        // 6a. hold blocks new grants
        set_mask(3, 8'h81);
        hold = 1'b1;
        req[3] = 1'b1;
        cyc(5);
        chk("hold_ack", 32'(ack), 32'h0);
        chk("hold_busy", 32'(busy), 32'h0);
        hold = 1'b0;
        exp_q.push_back(4'b1000);
        cyc(1);
        req[3] = 1'b0;
        cyc(1);
        chk("hold_release_q", 32'(q), 32'h81);

        // 6b. reset in the middle of GRANT (pointer is 0, req3 wins)
        req[3] = 1'b1;
        cyc(1);
        chk("midrst_ack_before", 32'(ack), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_q", 32'(q), 32'h00);
        chk("midrst_busy", 32'(busy), 32'h0);
        req = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("midrst_q_after", 32'(q), 32'h00);

        // after reset the pointer is 0, so req1 beats req3
        set_mask(1, 8'h3C);
        req = 4'b1010;
        exp_q.push_back(4'b0010);
        cyc(1);
        req = '0;
        cyc(1);
        chk("ptr_reset_q", 32'(q), 32'h3C);

        // wait for the monitor to drain the expected queue
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) cyc(1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
